// File: rtl/garegga_textrom_arbiter.sv
// Two-requester arbiter for the shared SDRAM-backed text-ROM read port, with ROM watchdog.
// Define TEXTROM_ARB_FIXPRIO_EN to give requester 0 fixed priority instead of round-robin.
module garegga_textrom_arbiter #(
  parameter int AW  = 14,
  parameter int DW  = 16,
  parameter int TMO = 255
) (
  input  logic          CLK96,
  input  logic          RESET96,
  input  logic          R0_REQ,
  input  logic [AW-1:0] R0_ADDR,
  output logic          R0_ACK,
  output logic [DW-1:0] R0_DATA,
  input  logic          R1_REQ,
  input  logic [AW-1:0] R1_ADDR,
  output logic          R1_ACK,
  output logic [DW-1:0] R1_DATA,
  output logic          ROM_CS,
  output logic [AW-1:0] ROM_ADDR,
  input  logic [DW-1:0] ROM_DATA,
  input  logic          ROM_OK,
  output logic          BUSY,
  output logic          TMO_ERR
);

  localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam logic [CW:0] TMO_LIM = (CW+1)'(TMO);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state_reg, state_next;
  logic          gnt_reg, gnt_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW:0]   cnt_inc;
  logic          rom_cs_reg, rom_cs_next;
  logic [AW-1:0] rom_addr_reg, rom_addr_next;
  logic          ack0_reg, ack0_next;
  logic          ack1_reg, ack1_next;
  logic [DW-1:0] data0_reg, data0_next;
  logic [DW-1:0] data1_reg, data1_next;
  logic          tmo_err_reg, tmo_err_next;
  logic          win;
  logic          fire;

`ifdef TEXTROM_ARB_FIXPRIO_EN
  assign win = ~R0_REQ;
`else
  logic rr_reg, rr_next;
  // rr_reg names the requester that wins a tie; 0 after reset.
  assign win = (R0_REQ & R1_REQ) ? rr_reg : R1_REQ;

  always_ff @(posedge CLK96) begin
    if (RESET96) rr_reg <= 1'b0;
    else         rr_reg <= rr_next;
  end
`endif

  assign cnt_inc = {1'b0, cnt_reg} + 1'b1;
  assign fire    = (TMO != 0) && (cnt_inc == TMO_LIM);

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    cnt_next      = cnt_reg;
    rom_cs_next   = rom_cs_reg;
    rom_addr_next = rom_addr_reg;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    data0_next    = data0_reg;
    data1_next    = data1_reg;
    tmo_err_next  = tmo_err_reg;
`ifndef TEXTROM_ARB_FIXPRIO_EN
    rr_next       = rr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (R0_REQ || R1_REQ) begin
          gnt_next      = win;
          rom_addr_next = win ? R1_ADDR : R0_ADDR;
          rom_cs_next   = 1'b1;
          cnt_next      = '0;
          state_next    = ISSUE;
        end
      end
      // ROM_OK is deliberately ignored here: it may still be high from the last access.
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (ROM_OK || fire) begin
          rom_cs_next = 1'b0;
          ack0_next   = ~gnt_reg;
          ack1_next   = gnt_reg;
          state_next  = ACK;
          if (gnt_reg) data1_next = ROM_OK ? ROM_DATA : '1;
          else         data0_next = ROM_OK ? ROM_DATA : '1;
          if (!ROM_OK) tmo_err_next = 1'b1;
        end else begin
          cnt_next = cnt_inc[CW-1:0];
        end
      end
      ACK: begin
`ifndef TEXTROM_ARB_FIXPRIO_EN
        rr_next = ~gnt_reg;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_reg    <= IDLE;
      gnt_reg      <= 1'b0;
      cnt_reg      <= '0;
      rom_cs_reg   <= 1'b0;
      rom_addr_reg <= '0;
      ack0_reg     <= 1'b0;
      ack1_reg     <= 1'b0;
      data0_reg    <= '0;
      data1_reg    <= '0;
      tmo_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      cnt_reg      <= cnt_next;
      rom_cs_reg   <= rom_cs_next;
      rom_addr_reg <= rom_addr_next;
      ack0_reg     <= ack0_next;
      ack1_reg     <= ack1_next;
      data0_reg    <= data0_next;
      data1_reg    <= data1_next;
      tmo_err_reg  <= tmo_err_next;
    end
  end

  assign R0_ACK   = ack0_reg;
  assign R1_ACK   = ack1_reg;
  assign R0_DATA  = data0_reg;
  assign R1_DATA  = data1_reg;
  assign ROM_CS   = rom_cs_reg;
  assign ROM_ADDR = rom_addr_reg;
  assign BUSY     = (state_reg != IDLE);
  assign TMO_ERR  = tmo_err_reg;

endmodule

// File: doc/garegga_textrom_arbiter.md
Name: garegga_textrom_arbiter

Overview:
- Shares one text-ROM read port (SDRAM-backed, variable latency) between two requesters: requester 0 is the extratext line renderer, requester 1 is the text-layer tile fetcher (or the CPU/debug reader).
- Sits between the requesters and the SDRAM ROM slot in the CLK96 domain.
- Handles request capture, grant selection, the ROM handshake and per-requester data return.

Parameters:
AW, 14, ROM word-address width
DW, 16, ROM data width
TMO, 255, watchdog limit in CLK96 cycles for a ROM access; 0 disables the watchdog

Ports:
CLK96  in  1  system clock; all logic on its rising edge
RESET96  in  1  synchronous, active-high reset
R0_REQ  in  1  requester 0 read request; level, held until R0_ACK
R0_ADDR  in  AW  requester 0 word address; stable while R0_REQ is high
R0_ACK  out  1  one-cycle pulse; R0_DATA is valid in the same cycle
R0_DATA  out  DW  read data for requester 0; held until the next R0_ACK
R1_REQ  in  1  requester 1 read request
R1_ADDR  in  AW  requester 1 word address
R1_ACK  out  1  one-cycle pulse
R1_DATA  out  DW  read data for requester 1
ROM_CS  out  1  ROM request; held high until ROM_OK is accepted
ROM_ADDR  out  AW  ROM word address
ROM_DATA  in  DW  ROM read data
ROM_OK  in  1  ROM data valid
BUSY  out  1  high in every state other than IDLE
TMO_ERR  out  1  sticky flag; set when the watchdog fires, cleared only by reset

Behaviour:
- Reset (RESET96 high at a clock edge) has priority over everything else:
  - State goes to IDLE.
  - ROM_CS, R0_ACK, R1_ACK, BUSY and TMO_ERR go to 0; ROM_ADDR, R0_DATA and R1_DATA go to 0.
  - The round-robin pointer resets to favour requester 0.
  - An in-flight ROM access is abandoned; any later ROM_OK is ignored because ROM_CS is 0.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any REQ is high, pick a winner, latch its index into gnt, drive ROM_ADDR from the winner's ADDR, set ROM_CS=1 and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: lasts exactly one cycle, then go to WAIT. ROM_OK is ignored here, which masks a stale ok still high from the previous access.
- WAIT:
  - On ROM_OK=1: capture ROM_DATA into the R*_DATA register selected by gnt, drop ROM_CS, go to ACK.
  - Otherwise increment the watchdog counter.
- ACK:
  - Pulse R[gnt]_ACK for one cycle.
  - Update the round-robin pointer to favour the requester that did not win (not gnt).
  - Return to IDLE.
- Minimum latency, from REQ sampled high in IDLE to ACK pulse: 4 cycles when ROM_OK is high on the first WAIT cycle. The next grant can be made in the cycle after ACK.
- Arbitration:
  - Only one requester asserting: it wins.
  - Both asserting in the same IDLE cycle: the round-robin pointer decides, so sustained dual requests alternate 0,1,0,1.
- A requester that drops REQ mid-access still receives its ACK pulse and data. Requesters must ignore an ACK they did not expect.
- A requester must not change ADDR while REQ is high. The arbiter latches the address at grant, so later changes have no effect on the access in flight.
- Watchdog (TMO nonzero):
  - The counter is cleared on entry to ISSUE.
  - If the counter reaches TMO in WAIT: set TMO_ERR, drop ROM_CS, load all-ones data into the granted R*_DATA, go to ACK.
  - This guarantees forward progress for the line renderer.
- The data register of the non-granted requester is never modified.
- ROM_ADDR holds its value after an access completes; it only changes at the next grant.

Optional Feature:
- Macro: TEXTROM_ARB_FIXPRIO_EN.
- Defined: requester 0 (extratext renderer) always wins a simultaneous request. The round-robin pointer is removed, and requester 1 is served only when R0_REQ is low in IDLE.
- Not defined: round-robin arbitration exactly as in Behaviour.

Test Plan:
- Single request: R0_REQ=1, R0_ADDR=14'h0123, ROM returns 16'hBEEF with ROM_OK one cycle after ISSUE -> ROM_ADDR=14'h0123 and ROM_CS=1 for 2 cycles; R0_ACK pulses once, 4 cycles after the request; R0_DATA=16'hBEEF; R1_DATA unchanged at 0.
- Simultaneous requests: both REQ high continuously, R0_ADDR=14'h0010, R1_ADDR=14'h0020, ROM_OK fixed at 3-cycle latency -> ROM_ADDR sequence 0010,0020,0010,0020; ACKs alternate R0,R1,R0,R1. With TEXTROM_ARB_FIXPRIO_EN defined, only R0 ACKs while R0_REQ stays high.
- Stale ok: ROM_OK held at 1 through ISSUE, then low for 5 cycles, then pulsed with 16'h1234 -> no ACK before the pulse; the ACK carries 16'h1234.
- Watchdog: TMO=8, ROM_OK never asserted -> TMO_ERR=1 after 8 WAIT cycles; R0_ACK pulses with R0_DATA=16'hFFFF; the next request is then served normally and TMO_ERR stays 1.
- Reset mid-access: RESET96 asserted during WAIT, then ROM_OK pulses after reset is released -> all outputs 0, no ACK, state IDLE; a fresh R1 request then completes normally.
- Requester drop: R1_REQ deasserted during WAIT -> R1_ACK still pulses once with the ROM data; BUSY returns to 0 the cycle after ACK.
